// File: rtl/spi_boot_loader.sv
// Boot sequencer: wakes the SPI flash, streams an image into BRAM over a mode-0
// read, then releases the core by raising boot.
module spi_boot_loader #(
    parameter logic [23:0] FLASH_BASE  = 24'h100000,
    parameter int          NWORDS      = 1024,
    parameter int          ADDR_W      = 10,
    parameter int          CLK_DIV     = 2,
    parameter int          WAKE_CYCLES = 64
) (
    input  logic              clk,
    input  logic              resetb,
    output logic              spi_csb,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              boot,
    output logic              busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAKE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W + 1)'(NWORDS - 1);
    localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W + 1)'(1);
    localparam logic [31:0]       WAKE_WORD = {8'hAB, 24'h000000};
    localparam logic [31:0]       READ_WORD = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        WAKE_CMD  = 3'd0,
        WAKE_WAIT = 3'd1,
        RD_CMD    = 3'd2,
        RD_DATA   = 3'd3,
        FINISH    = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t              state_r;
    logic                csb_r;
    logic                sck_r;
    logic                mosi_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic                boot_r;
    logic                busy_r;
    logic [30:0]         tx_sr_r;
    logic [5:0]          bit_cnt_r;
    logic [DIV_W-1:0]    div_r;
    logic [WAIT_W-1:0]   wait_r;
    logic [31:0]         word_r;
    logic [ADDR_W:0]     word_idx_r;
    logic                wr_pend_r;
    logic                last_word_r;
    logic                tick_s;

    // Bytes arrive MSB first but are packed little-endian into the word.
    function automatic logic [4:0] le_bit_pos(input logic [4:0] n);
        return {n[4:3], ~n[2:0]};
    endfunction

    assign tick_s = (div_r == DIV_LAST);

    // Sequencer, SCK generator, word assembly and BRAM write port.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r     <= WAKE_CMD;
            csb_r       <= 1'b1;
            sck_r       <= 1'b0;
            mosi_r      <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            boot_r      <= 1'b0;
            busy_r      <= 1'b1;
            tx_sr_r     <= '0;
            bit_cnt_r   <= 6'd0;
            div_r       <= '0;
            wait_r      <= '0;
            word_r      <= 32'h0000_0000;
            word_idx_r  <= '0;
            wr_pend_r   <= 1'b0;
            last_word_r <= 1'b0;
        end else begin
            we_r <= 1'b0;
            if (wr_pend_r) begin
                we_r       <= 1'b1;
                addr_r     <= word_idx_r[ADDR_W-1:0];
                wdata_r    <= word_r;
                word_idx_r <= word_idx_r + IDX_ONE;
                wr_pend_r  <= 1'b0;
            end else begin
                wr_pend_r <= 1'b0;
            end

            case (state_r)
                WAKE_CMD: begin
                    if (csb_r) begin
                        csb_r     <= 1'b0;
                        mosi_r    <= WAKE_WORD[31];
                        tx_sr_r   <= WAKE_WORD[30:0];
                        div_r     <= '0;
                        bit_cnt_r <= 6'd0;
                    end else if (!tick_s) begin
                        div_r <= div_r + DIV_ONE;
                    end else if (!sck_r) begin
                        div_r <= '0;
                        if (bit_cnt_r == 6'd8) begin
                            csb_r   <= 1'b1;
                            wait_r  <= '0;
                            state_r <= WAKE_WAIT;
                        end else begin
                            sck_r     <= 1'b1;
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end
                    end else begin
                        div_r   <= '0;
                        sck_r   <= 1'b0;
                        mosi_r  <= tx_sr_r[30];
                        tx_sr_r <= {tx_sr_r[29:0], 1'b0};
                    end
                end
                WAKE_WAIT: begin
                    if (wait_r == WAIT_LAST) begin
                        csb_r     <= 1'b0;
                        mosi_r    <= READ_WORD[31];
                        tx_sr_r   <= READ_WORD[30:0];
                        div_r     <= '0;
                        bit_cnt_r <= 6'd0;
                        state_r   <= RD_CMD;
                    end else begin
                        wait_r <= wait_r + WAIT_ONE;
                    end
                end
                RD_CMD: begin
                    if (!tick_s) begin
                        div_r <= div_r + DIV_ONE;
                    end else if (!sck_r) begin
                        div_r     <= '0;
                        sck_r     <= 1'b1;
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end else begin
                        div_r   <= '0;
                        sck_r   <= 1'b0;
                        mosi_r  <= tx_sr_r[30];
                        tx_sr_r <= {tx_sr_r[29:0], 1'b0};
                        if (bit_cnt_r == 6'd32) begin
                            bit_cnt_r <= 6'd0;
                            state_r   <= RD_DATA;
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end
                end
                RD_DATA: begin
                    if (!tick_s) begin
                        div_r <= div_r + DIV_ONE;
                    end else if (!sck_r) begin
                        div_r     <= '0;
                        sck_r     <= 1'b1;
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                        word_r[le_bit_pos(bit_cnt_r[4:0])] <= spi_miso;
                        if (bit_cnt_r == 6'd31) begin
                            wr_pend_r   <= 1'b1;
                            last_word_r <= (word_idx_r == LAST_IDX);
                        end else begin
                            last_word_r <= last_word_r;
                        end
                    end else begin
                        div_r <= '0;
                        sck_r <= 1'b0;
                        if (bit_cnt_r == 6'd32) begin
                            bit_cnt_r <= 6'd0;
                            state_r   <= last_word_r ? FINISH : RD_DATA;
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end
                end
                FINISH: begin
                    if (tick_s) begin
                        csb_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                DONE: begin
                    boot_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    state_r <= WAKE_CMD;
                end
            endcase
        end
    end

    assign spi_csb   = csb_r;
    assign spi_sck   = sck_r;
    assign spi_mosi  = mosi_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign boot      = boot_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench for spi_boot_loader: three configurations share one clock,
// each with a behavioural mode-0 flash and bus monitors sampled on the falling edge.
module tb_spi_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] img [16] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                             8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    function automatic logic img_bit(input int j);
        logic [7:0] b;
        b = img[(j / 8) % 16];
        return b[7 - (j % 8)];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- DUT A: NWORDS=4, CLK_DIV=1 ----------------
    logic a_rstn, a_csb, a_sck, a_mosi, a_miso, a_we, a_boot, a_busy;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic a_p_sck = 1'b0, a_p_csb = 1'b1, a_p_we = 1'b0, a_p_boot = 1'b0;
    int a_sess = 0, a_rises = 0, a_gap = 0, a_gap_last = 0, a_n_wake = 0;
    int a_rd_len = 0, a_nwr = 0, a_we2 = 0, a_bb_bad = 0, a_boot_rises = 0;
    logic [31:0] a_shift = 32'h0, a_rd_cmd = 32'h0;
    logic [7:0]  a_wake_cmd = 8'h00;
    logic [9:0]  a_wa [16];
    logic [31:0] a_wd [16];

    spi_boot_loader #(.FLASH_BASE(24'h100000), .NWORDS(4), .ADDR_W(10), .CLK_DIV(1), .WAKE_CYCLES(6)) u_a (
        .clk(clk), .resetb(a_rstn), .spi_csb(a_csb), .spi_sck(a_sck), .spi_mosi(a_mosi),
        .spi_miso(a_miso), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .boot(a_boot), .busy(a_busy));

    assign a_miso = (!a_csb && a_sess >= 32) ? img_bit(a_sess - 32) : 1'b0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        a_p_sck  <= a_sck;
        a_p_csb  <= a_csb;
        a_p_we   <= a_we;
        a_p_boot <= a_boot;
        if (!a_csb && a_p_csb) begin
            a_sess     <= 0;
            a_shift    <= 32'h0;
            a_gap_last <= a_gap;
        end else if (a_sck && !a_p_sck) begin
            a_sess  <= a_sess + 1;
            a_rises <= a_rises + 1;
            if (a_sess < 32) a_shift <= {a_shift[30:0], a_mosi};
        end
        if (a_csb && !a_p_csb) begin
            a_gap <= 1;
            if (a_sess == 8) begin
                a_wake_cmd <= a_shift[7:0];
                if (a_shift[7:0] == 8'hAB) a_n_wake <= a_n_wake + 1;
            end else begin
                a_rd_cmd <= a_shift;
                a_rd_len <= a_sess;
            end
        end else if (a_csb) begin
            a_gap <= a_gap + 1;
        end
        if (a_we) begin
            if (a_nwr < 16) begin
                a_wa[a_nwr] <= a_addr;
                a_wd[a_nwr] <= a_wdata;
            end
            a_nwr <= a_nwr + 1;
            if (a_p_we) a_we2 <= a_we2 + 1;
        end
        if (a_boot === a_busy) a_bb_bad <= a_bb_bad + 1;
        if (a_boot && !a_p_boot) a_boot_rises <= a_boot_rises + 1;
    end

    // ---------------- DUT B: NWORDS=1, CLK_DIV=3 ----------------
    logic b_rstn, b_csb, b_sck, b_mosi, b_miso, b_we, b_boot, b_busy;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic b_p_sck = 1'b0, b_p_csb = 1'b1, b_p_mosi = 1'b0, b_p_boot = 1'b0;
    int b_sess = 0, b_rises = 0, b_run = 0, b_phase_chk = 0, b_phase_bad = 0, b_mosi_bad = 0;
    int b_nwr = 0, b_last_rise_cyc = 0, b_we_cyc = 0, b_csb_rise_cyc = 0, b_boot_cyc = 0;
    logic [9:0]  b_wa0 = 10'h3FF;
    logic [31:0] b_wd0 = 32'h0;

    spi_boot_loader #(.FLASH_BASE(24'h100000), .NWORDS(1), .ADDR_W(10), .CLK_DIV(3), .WAKE_CYCLES(6)) u_b (
        .clk(clk), .resetb(b_rstn), .spi_csb(b_csb), .spi_sck(b_sck), .spi_mosi(b_mosi),
        .spi_miso(b_miso), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .boot(b_boot), .busy(b_busy));

    assign b_miso = (!b_csb && b_sess >= 32) ? img_bit(b_sess - 32) : 1'b0;

    always @(negedge clk) begin
        b_p_sck  <= b_sck;
        b_p_csb  <= b_csb;
        b_p_mosi <= b_mosi;
        b_p_boot <= b_boot;
        if (!b_csb && b_p_csb) b_sess <= 0;
        else if (b_sck && !b_p_sck) b_sess <= b_sess + 1;
        if (b_sck && !b_p_sck) begin
            b_rises         <= b_rises + 1;
            b_last_rise_cyc <= cyc;
        end
        if (!b_csb && b_p_csb) begin
            b_run <= 1;
        end else if (!b_csb && b_sck != b_p_sck) begin
            b_run       <= 1;
            b_phase_chk <= b_phase_chk + 1;
            if (b_run != 3) b_phase_bad <= b_phase_bad + 1;
        end else if (b_csb && !b_p_csb) begin
            b_phase_chk    <= b_phase_chk + 1;
            b_csb_rise_cyc <= cyc;
            if (b_run != 3) b_phase_bad <= b_phase_bad + 1;
        end else begin
            b_run <= b_run + 1;
        end
        if (b_sck && b_p_sck && b_mosi !== b_p_mosi) b_mosi_bad <= b_mosi_bad + 1;
        if (b_we) begin
            b_nwr    <= b_nwr + 1;
            b_we_cyc <= cyc;
            b_wa0    <= b_addr;
            b_wd0    <= b_wdata;
        end
        if (b_boot && !b_p_boot) b_boot_cyc <= cyc;
    end

    // ---------------- DUT C: ADDR_W=2, NWORDS=4, CLK_DIV=2 ----------------
    logic c_rstn, c_csb, c_sck, c_mosi, c_miso, c_we, c_boot, c_busy;
    logic [1:0]  c_addr;
    logic [31:0] c_wdata;
    logic c_p_sck = 1'b0, c_p_csb = 1'b1;
    int c_sess = 0, c_nwr = 0;
    logic [1:0]  c_wa [8];
    logic [31:0] c_wd [8];

    spi_boot_loader #(.FLASH_BASE(24'h100000), .NWORDS(4), .ADDR_W(2), .CLK_DIV(2), .WAKE_CYCLES(6)) u_c (
        .clk(clk), .resetb(c_rstn), .spi_csb(c_csb), .spi_sck(c_sck), .spi_mosi(c_mosi),
        .spi_miso(c_miso), .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata),
        .boot(c_boot), .busy(c_busy));

    assign c_miso = (!c_csb && c_sess >= 32) ? img_bit(c_sess - 32) : 1'b0;

    always @(negedge clk) begin
        c_p_sck <= c_sck;
        c_p_csb <= c_csb;
        if (!c_csb && c_p_csb) c_sess <= 0;
        else if (c_sck && !c_p_sck) c_sess <= c_sess + 1;
        if (c_we) begin
            if (c_nwr < 8) begin
                c_wa[c_nwr] <= c_addr;
                c_wd[c_nwr] <= c_wdata;
            end
            c_nwr <= c_nwr + 1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        a_rstn = 1'b0;
        b_rstn = 1'b0;
        c_rstn = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("hold_reset_a", {a_csb, a_sck, a_mosi, a_we, a_boot, a_busy}, 6'b100001);
        end
        chk("hold_reset_addr", a_addr, 10'h000);
        chk("hold_reset_wdata", a_wdata, 32'h0);
        chk("hold_reset_b", {b_csb, b_sck, b_boot, b_busy}, 4'b1001);
        chk("hold_reset_rises", a_rises, 0);
        chk("hold_reset_writes", a_nwr, 0);

        a_rstn = 1'b1;
        b_rstn = 1'b1;
        c_rstn = 1'b1;

        for (int i = 0; i < 3000 && a_boot !== 1'b1; i++) @(negedge clk);
        chk("a_boot_timeout", a_boot, 1'b1);
        repeat (5) @(negedge clk);
        chk("a_wake_cmd", a_wake_cmd, 8'hAB);
        chk("a_wake_gap", a_gap_last, 6);
        chk("a_read_cmd", a_rd_cmd, 32'h03100000);
        chk("a_read_bits", a_rd_len, 160);
        chk("a_sck_rises", a_rises, 168);
        chk("a_writes", a_nwr, 4);
        chk("a_addr0", a_wa[0], 10'd0);
        chk("a_data0", a_wd[0], 32'h00000013);
        chk("a_addr1", a_wa[1], 10'd1);
        chk("a_data1", a_wd[1], 32'h00100093);
        chk("a_addr2", a_wa[2], 10'd2);
        chk("a_data2", a_wd[2], 32'h12345678);
        chk("a_addr3", a_wa[3], 10'd3);
        chk("a_data3", a_wd[3], 32'hDEADBEEF);
        chk("a_we_back_to_back", a_we2, 0);
        chk("a_boot_busy_complement", a_bb_bad, 0);
        chk("a_boot_rises", a_boot_rises, 1);

        for (int i = 0; i < 3000 && c_boot !== 1'b1; i++) @(negedge clk);
        chk("c_boot_timeout", c_boot, 1'b1);
        for (int i = 0; i < 3000 && b_boot !== 1'b1; i++) @(negedge clk);
        chk("b_boot_timeout", b_boot, 1'b1);

        repeat (50) @(negedge clk);
        chk("a_done_boot", {a_boot, a_busy, a_csb, a_sck}, 4'b1010);
        chk("a_done_rises", a_rises, 168);
        chk("a_done_writes", a_nwr, 4);

        chk("b_sck_rises", b_rises, 72);
        chk("b_phase_checks", b_phase_chk, 146);
        chk("b_phase_len", b_phase_bad, 0);
        chk("b_mosi_stable", b_mosi_bad, 0);
        chk("b_writes", b_nwr, 1);
        chk("b_addr0", b_wa0, 10'd0);
        chk("b_data0", b_wd0, 32'h00000013);
        chk("b_write_latency", b_we_cyc - b_last_rise_cyc, 1);
        chk("b_boot_latency", b_boot_cyc - b_csb_rise_cyc, 1);

        chk("c_writes", c_nwr, 4);
        chk("c_addr0", c_wa[0], 2'd0);
        chk("c_addr1", c_wa[1], 2'd1);
        chk("c_addr2", c_wa[2], 2'd2);
        chk("c_addr3", c_wa[3], 2'd3);
        chk("c_data3", c_wd[3], 32'hDEADBEEF);
        chk("c_done", {c_boot, c_busy, c_csb}, 3'b101);

        // Restart A and abort it asynchronously while word 2 is being shifted in.
        a_rstn = 1'b0;
        repeat (3) @(negedge clk);
        a_rstn = 1'b1;
        for (int i = 0; i < 3000 && a_nwr < 6; i++) @(negedge clk);
        chk("abort_two_words", a_nwr, 6);
        chk("abort_addr1", a_wa[5], 10'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 a_rstn = 1'b0;
        #1;
        chk("abort_outs", {a_csb, a_sck, a_mosi, a_we, a_boot, a_busy}, 6'b100001);
        chk("abort_addr", a_addr, 10'h000);
        chk("abort_wdata", a_wdata, 32'h0);
        repeat (20) @(negedge clk);
        chk("abort_no_write", a_nwr, 6);
        chk("abort_idle", {a_csb, a_sck}, 2'b10);
        a_rstn = 1'b1;

        for (int i = 0; i < 3000 && a_boot !== 1'b1; i++) @(negedge clk);
        chk("restart_boot_timeout", a_boot, 1'b1);
        repeat (20) @(negedge clk);
        chk("restart_wake_count", a_n_wake, 3);
        chk("restart_writes", a_nwr, 10);
        chk("restart_addr0", a_wa[6], 10'd0);
        chk("restart_data0", a_wd[6], 32'h00000013);
        chk("restart_addr3", a_wa[9], 10'd3);
        chk("restart_data2", a_wd[8], 32'h12345678);
        chk("restart_read_bits", a_rd_len, 160);
        chk("restart_boot_rises", a_boot_rises, 2);
        chk("restart_we_back_to_back", a_we2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
